// File: rtl/btn_ctrl_pkg.sv
// Shared definitions for the push-button enable generator:
// FSM state encoding and default timing parameters.
package btn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESS_CHK   = 3'd1,
    ST_HELD        = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_RELEASE_CHK = 3'd4
  } btn_state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_REPEAT_DELAY    = 64;
  localparam int unsigned DEF_REPEAT_PERIOD   = 16;
  localparam int unsigned DEF_CNT_W           = 16;

endpackage

// File: rtl/sync_ff.sv
// N-stage synchroniser for a single asynchronous bit.
// Ports: clk, reset (async active-low, clears all stages to 0),
//        d (asynchronous input), q (synchronised output, last stage).
module sync_ff
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift chain; the first stage is the only one that may go metastable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/btn_enable_gen.sv
// Turns a raw, bouncy push-button into clean single-cycle enable pulses,
// with press/release debounce and optional hold-to-auto-repeat.
// Ports: clk, reset (async active-low), btn_in (raw async button, 1=pressed),
//        repeat_en (1 = auto-repeat while held), enable (registered one-cycle
//        step pulse), btn_level (registered debounced level).
module btn_enable_gen
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic enable,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             btn_sync;
  btn_state_t       state;
  logic [CNT_W-1:0] timer;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (btn_sync)
  );

  // Debounce/repeat FSM with its timer and registered outputs.
  // Release is checked first in HELD/REPEAT so it wins over a terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      enable    <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      enable <= 1'b0;
      // Saturate so a long idle/hold can never wrap into a false terminal count.
      if (timer != '1) timer <= timer + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (btn_sync) state <= ST_PRESS_CHK;
        end
        ST_PRESS_CHK: begin
          if (!btn_sync) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            state     <= ST_HELD;
            timer     <= '0;
            enable    <= 1'b1;
            btn_level <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!btn_sync) begin
            state <= ST_RELEASE_CHK;
            timer <= '0;
          end else if (repeat_en && (timer == RD_LAST)) begin
            state  <= ST_REPEAT;
            timer  <= '0;
            enable <= 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!btn_sync) begin
            state <= ST_RELEASE_CHK;
            timer <= '0;
          end else if (!repeat_en) begin
            state <= ST_HELD;
            timer <= '0;
          end else if (timer == RP_LAST) begin
            timer  <= '0;
            enable <= 1'b1;
          end
        end
        ST_RELEASE_CHK: begin
          if (btn_sync) begin
            state <= ST_HELD;
            timer <= '0;
          end else if (timer == DB_LAST) begin
            state     <= ST_IDLE;
            timer     <= '0;
            btn_level <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          timer     <= '0;
          enable    <= 1'b0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_enable_gen.sv
// Self-checking bench for btn_enable_gen with a pulse-time scoreboard and a
// downstream 4-bit up counter model.
module tb_btn_enable_gen;

  localparam int unsigned LAT = 7;

  logic clk;
  logic reset;
  logic btn_in;
  logic repeat_en;
  logic enable;
  logic btn_level;

  int   cyc;
  int   total;
  int   bad;
  int   exp_q[$];
  logic prev_en;
  logic [3:0] cnt;

  btn_enable_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .repeat_en(repeat_en),
    .enable   (enable),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 4-bit up counter driven by enable.
  always @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= 4'd0;
    else if (enable) cnt <= cnt + 4'd1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every enable pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0] < cyc)
      chk("missed_pulse", cyc, exp_q.pop_front());
    if (enable === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_pulse", cyc, -1);
      else                   chk("pulse_cyc", cyc, exp_q.pop_front());
      chk("adjacent_pulse", int'(prev_en), 0);
    end
    prev_en = enable;
  end

  // Press at the current negedge, hold for 'hold' cycles, queue expected pulses.
  task automatic press(input int hold, input bit rep);
    int c0;
    c0 = cyc;
    btn_in = 1'b1;
    exp_q.push_back(c0 + LAT);
    if (rep)
      for (int t = c0 + 15; t <= c0 + hold + 2; t += 3) exp_q.push_back(t);
    wait_to(c0 + hold);
    btn_in = 1'b0;
  endtask

  initial begin
    int c0;
    int r0;
    clk = 1'b0;
    reset = 1'b0;
    btn_in = 1'b0;
    repeat_en = 1'b0;
    cyc = 0;
    total = 0;
    bad = 0;
    prev_en = 1'b0;

    @(negedge clk);
    chk("rst_enable", int'(enable), 0);
    chk("rst_level", int'(btn_level), 0);
    @(negedge clk);
    reset = 1'b1;
    wait_to(cyc + 10);
    chk("rst_release_level", int'(btn_level), 0);

    // 1: clean press, no repeat
    c0 = cyc;
    btn_in = 1'b1;
    exp_q.push_back(c0 + LAT);
    wait_to(c0 + LAT - 1);
    chk("s1_level_pre", int'(btn_level), 0);
    wait_to(c0 + LAT);
    chk("s1_level_on", int'(btn_level), 1);
    wait_to(c0 + 30);
    btn_in = 1'b0;
    r0 = cyc;
    wait_to(r0 + LAT - 1);
    chk("s1_level_hold", int'(btn_level), 1);
    wait_to(r0 + LAT);
    chk("s1_level_off", int'(btn_level), 0);
    wait_to(r0 + 10);
    chk("s1_pending", exp_q.size(), 0);

    // 2: bounce, then stable press
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      btn_in = (k % 2 == 0);
      wait_to(c0 + 2 * (k + 1));
    end
    chk("s2_no_level", int'(btn_level), 0);
    btn_in = 1'b1;
    exp_q.push_back(cyc + LAT);
    wait_to(cyc + 20);
    btn_in = 1'b0;
    wait_to(cyc + 12);
    chk("s2_pending", exp_q.size(), 0);

    // 3: auto-repeat
    repeat_en = 1'b1;
    press(40, 1'b1);
    wait_to(cyc + 12);
    chk("s3_pending", exp_q.size(), 0);
    chk("s3_level_off", int'(btn_level), 0);

    // 4: release glitch while held, no repeat
    repeat_en = 1'b0;
    c0 = cyc;
    btn_in = 1'b1;
    exp_q.push_back(c0 + LAT);
    wait_to(c0 + 12);
    btn_in = 1'b0;
    wait_to(c0 + 14);
    btn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("s4_level_glitch", int'(btn_level), 1);
    end
    wait_to(c0 + 40);
    btn_in = 1'b0;
    wait_to(cyc + 12);
    chk("s4_pending", exp_q.size(), 0);

    // 5: async reset in the middle of REPEAT
    repeat_en = 1'b1;
    c0 = cyc;
    btn_in = 1'b1;
    exp_q.push_back(c0 + LAT);
    exp_q.push_back(c0 + 15);
    exp_q.push_back(c0 + 18);
    wait_to(c0 + 18);
    chk("s5_pre_enable", int'(enable), 1);
    #1 reset = 1'b0;
    #1;
    chk("s5_async_enable", int'(enable), 0);
    chk("s5_async_level", int'(btn_level), 0);
    repeat_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    r0 = cyc;
    exp_q.push_back(r0 + LAT);
    wait_to(r0 + LAT - 1);
    chk("s5_level_pre", int'(btn_level), 0);
    wait_to(r0 + 20);
    btn_in = 1'b0;
    wait_to(cyc + 12);
    chk("s5_pending", exp_q.size(), 0);

    // 6: 17 presses into the 4-bit counter
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_to(cyc + 3);
    chk("s6_cnt_start", int'(cnt), 0);
    for (int i = 0; i < 17; i++) begin
      c0 = cyc;
      press(12, 1'b0);
      wait_to(c0 + 24);
      chk("s6_cnt_step", int'(cnt), (i + 1) % 16);
    end
    chk("s6_cnt_final", int'(cnt), 1);
    chk("s6_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
